// File: rtl/syscnt_checker.sv
// -----------------------------------------------------------------------------
// SyscntChecker (module syscnt_checker)
//
// Watches the value produced by an upstream free-running counter. It checks
// that every accepted sample is exactly one more than the previous sample,
// with wrap-around modulo 2^CNT_W. The checker first has to see SYNC_LEN
// consecutive correct increments before it reports lock. Once it is locked,
// any wrong increment is reported as a sequence error.
//
// Parameters:
//   CNT_W     width of the monitored counter value
//   SYNC_LEN  consecutive correct increments needed to lock (1..15)
//   ERR_W     width of the saturating error counter
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   en          sample-valid qualifier for syscnt
//   syscnt      counter value from the upstream block
//   clr_err     synchronous clear of err_sticky / err_cnt
//   locked      high while a valid increment sequence is being tracked
//   err_pulse   one-cycle strobe on each sequence error
//   err_sticky  latched error flag
//   err_cnt     saturating count of sequence errors
//   wrap_cnt    saturating count of wrap-arounds seen while locked
//               (only present when SYSCNT_CHK_WRAP_CNT_EN is defined)
//
// Build option:
//   SYSCNT_CHK_WRAP_CNT_EN  adds the wrap_cnt port and its counter
// -----------------------------------------------------------------------------
module syscnt_checker #(
  parameter int CNT_W    = 4,
  parameter int SYNC_LEN = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] syscnt,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt
`ifdef SYSCNT_CHK_WRAP_CNT_EN
  ,
  output logic [15:0]      wrap_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [3:0]       SYNC_LEN_4 = 4'(SYNC_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_exp, w_exp_next;
  logic [3:0]       r_good_run, w_good_run_next;
  logic             r_locked;
  logic             r_err_pulse;
  logic             r_err_sticky, w_err_sticky_next;
  logic [ERR_W-1:0] r_err_cnt, w_err_cnt_next;

  logic [CNT_W-1:0] w_inc;
  logic             w_match;
  logic             w_err;

  // The expected value always advances from the sample that was just seen,
  // so it re-aligns after a mismatch. Wrap-around comes from the CNT_W-bit add.
  assign w_inc   = syscnt + CNT_ONE;
  assign w_match = (syscnt == r_exp);

  // Next-state logic for the sequence tracker. Nothing moves without en.
  always_comb begin
    w_state_next    = r_state;
    w_exp_next      = r_exp;
    w_good_run_next = r_good_run;
    w_err           = 1'b0;
    if (en) begin
      case (r_state)
        IDLE: begin
          w_exp_next      = w_inc;
          w_good_run_next = 4'd0;
          w_state_next    = SYNC;
        end
        SYNC: begin
          w_exp_next = w_inc;
          if (w_match) begin
            w_good_run_next = r_good_run + 4'd1;
            if ((r_good_run + 4'd1) == SYNC_LEN_4) begin
              w_state_next = LOCK;
            end
          end else begin
            // A mismatch before lock only restarts the run. It is not an error.
            w_good_run_next = 4'd0;
          end
        end
        LOCK: begin
          w_exp_next = w_inc;
          if (!w_match) begin
            w_err           = 1'b1;
            w_good_run_next = 4'd0;
            w_state_next    = SYNC;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // Error status. A new error outranks a coincident clear, so the count
  // restarts at one rather than zero.
  always_comb begin
    w_err_sticky_next = r_err_sticky;
    w_err_cnt_next    = r_err_cnt;
    if (w_err) begin
      w_err_sticky_next = 1'b1;
      if (clr_err) begin
        w_err_cnt_next = ERR_ONE;
      end else if (r_err_cnt != ERR_MAX) begin
        w_err_cnt_next = r_err_cnt + ERR_ONE;
      end
    end else if (clr_err) begin
      w_err_sticky_next = 1'b0;
      w_err_cnt_next    = '0;
    end
  end

  // State and output registers. locked is taken from the next state, so it
  // rises on the same edge that enters LOCK.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_exp        <= '0;
      r_good_run   <= 4'd0;
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_exp        <= w_exp_next;
      r_good_run   <= w_good_run_next;
      r_locked     <= (w_state_next == LOCK);
      r_err_pulse  <= w_err;
      r_err_sticky <= w_err_sticky_next;
      r_err_cnt    <= w_err_cnt_next;
    end
  end

  assign locked     = r_locked;
  assign err_pulse  = r_err_pulse;
  assign err_sticky = r_err_sticky;
  assign err_cnt    = r_err_cnt;

`ifdef SYSCNT_CHK_WRAP_CNT_EN
  logic [15:0] r_wrap_cnt;
  logic        w_wrap;

  // A wrap is a correct increment into zero while already locked.
  assign w_wrap = en && (r_state == LOCK) && w_match && (syscnt == '0);

  // Only reset clears this counter. clr_err has no effect on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrap_cnt <= 16'h0000;
    end else if (w_wrap && (r_wrap_cnt != 16'hFFFF)) begin
      r_wrap_cnt <= r_wrap_cnt + 16'h0001;
    end
  end

  assign wrap_cnt = r_wrap_cnt;
`endif

endmodule

// File: tb/tb_syscnt_checker.sv
// -----------------------------------------------------------------------------
// TbSyscntChecker (module tb_syscnt_checker)
//
// Directed bench for syscnt_checker with the default parameters
// (CNT_W=4, SYNC_LEN=2, ERR_W=8). Each applied cycle pushes the outputs
// expected after that edge into a queue. A separate monitor pops one entry
// on every falling edge and compares it against the DUT. wrap_cnt is only
// connected and checked when SYSCNT_CHK_WRAP_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_syscnt_checker;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] syscnt;
  logic       clr_err;
  logic       locked;
  logic       err_pulse;
  logic       err_sticky;
  logic [7:0] err_cnt;
`ifdef SYSCNT_CHK_WRAP_CNT_EN
  logic [15:0] wrap_cnt;
`endif

  typedef struct packed {
    logic        locked;
    logic        pulse;
    logic        sticky;
    logic [7:0]  cnt;
    logic [15:0] wrap;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];
  int    vectorsApplied;
  int    miscompares;
  logic [3:0] expVal;

  syscnt_checker #(
    .CNT_W   (4),
    .SYNC_LEN(2),
    .ERR_W   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .syscnt    (syscnt),
    .clr_err   (clr_err),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_sticky(err_sticky),
    .err_cnt   (err_cnt)
`ifdef SYSCNT_CHK_WRAP_CNT_EN
    ,
    .wrap_cnt  (wrap_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one cycle of inputs and queues the outputs expected after the edge.
  task automatic applyStimulus(input logic rIn, input logic eIn, input logic cIn,
                               input logic [3:0] sIn, input logic xLocked,
                               input logic xPulse, input logic xSticky,
                               input logic [7:0] xCnt, input logic [15:0] xWrap,
                               input string nm);
    exp_t e;
    rst     = rIn;
    en      = eIn;
    clr_err = cIn;
    syscnt  = sIn;
    @(posedge clk);
    e.locked = xLocked;
    e.pulse  = xPulse;
    e.sticky = xSticky;
    e.cnt    = xCnt;
    e.wrap   = xWrap;
    expQ.push_back(e);
    nameQ.push_back(nm);
    @(negedge clk);
  endtask

  task automatic checkOutput(input exp_t e, input string nm);
    logic wrapBad;
    logic [15:0] wrapAct;
    wrapBad = 1'b0;
    wrapAct = e.wrap;
`ifdef SYSCNT_CHK_WRAP_CNT_EN
    wrapAct = wrap_cnt;
    wrapBad = (wrap_cnt !== e.wrap);
`endif
    vectorsApplied++;
    if ((locked !== e.locked) || (err_pulse !== e.pulse) ||
        (err_sticky !== e.sticky) || (err_cnt !== e.cnt) || wrapBad) begin
      miscompares++;
      $display("[TB] FAIL %s: got locked=%0b pulse=%0b sticky=%0b cnt=%0d wrap=%0d, want locked=%0b pulse=%0b sticky=%0b cnt=%0d wrap=%0d",
               nm, locked, err_pulse, err_sticky, err_cnt, wrapAct,
               e.locked, e.pulse, e.sticky, e.cnt, e.wrap);
    end
  endtask

  // Monitor: outputs are registered, so they are settled by the falling edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e  = expQ.pop_front();
        nm = nameQ.pop_front();
        checkOutput(e, nm);
      end
    end
  end

  initial begin
    vectorsApplied = 0;
    miscompares    = 0;
    rst = 1'b1; en = 1'b0; clr_err = 1'b0; syscnt = 4'd0;
    @(negedge clk);

    // Reset state
    applyStimulus(1, 0, 0, 4'd0, 0, 0, 0, 8'd0, 16'd0, "reset");
    applyStimulus(1, 1, 1, 4'd5, 0, 0, 0, 8'd0, 16'd0, "resetPrio");

    // Start-up: 0,1,2 locks after sample 2
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, 0, 4'(i), (i >= 2), 0, 0, 8'd0, 16'd0, "startup");

    // Injected error: 5 where 4 is expected, then relock on 6,7
    applyStimulus(0, 1, 0, 4'd5, 0, 1, 1, 8'd1, 16'd0, "injErr");
    applyStimulus(0, 1, 0, 4'd6, 0, 0, 1, 8'd1, 16'd0, "relock6");
    applyStimulus(0, 1, 0, 4'd7, 1, 0, 1, 8'd1, 16'd0, "relock7");

    // en gap with a wrong value present, then the correct next value
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 0, 0, 4'd9, 1, 0, 1, 8'd1, 16'd0, "enGap");
    applyStimulus(0, 1, 0, 4'd8, 1, 0, 1, 8'd1, 16'd0, "afterGap");

    // Plain clear alongside a good sample
    applyStimulus(0, 1, 1, 4'd9, 1, 0, 0, 8'd0, 16'd0, "clrErr");

    // Build err_cnt to 3. An en=0 cycle right after an error drops the pulse.
    applyStimulus(0, 1, 0, 4'd0,  0, 1, 1, 8'd1, 16'd0, "err1");
    applyStimulus(0, 1, 0, 4'd1,  0, 0, 1, 8'd1, 16'd0, "sync1");
    applyStimulus(0, 1, 0, 4'd2,  1, 0, 1, 8'd1, 16'd0, "lock1");
    applyStimulus(0, 1, 0, 4'd5,  0, 1, 1, 8'd2, 16'd0, "err2");
    applyStimulus(0, 1, 0, 4'd6,  0, 0, 1, 8'd2, 16'd0, "sync2");
    applyStimulus(0, 1, 0, 4'd7,  1, 0, 1, 8'd2, 16'd0, "lock2");
    applyStimulus(0, 1, 0, 4'd12, 0, 1, 1, 8'd3, 16'd0, "err3");
    applyStimulus(0, 0, 0, 4'd12, 0, 0, 1, 8'd3, 16'd0, "pulseDrop");
    applyStimulus(0, 1, 0, 4'd13, 0, 0, 1, 8'd3, 16'd0, "sync3");
    applyStimulus(0, 1, 0, 4'd14, 1, 0, 1, 8'd3, 16'd0, "lock3");

    // Clear colliding with a LOCK mismatch: the error wins
    applyStimulus(0, 1, 1, 4'd3, 0, 1, 1, 8'd1, 16'd0, "clrCollide");
    applyStimulus(0, 1, 0, 4'd4, 0, 0, 1, 8'd1, 16'd0, "sync4");
    applyStimulus(0, 1, 0, 4'd5, 1, 0, 1, 8'd1, 16'd0, "lock4");

    // Back to err_cnt=3 while locked, then reset mid-LOCK
    applyStimulus(0, 1, 0, 4'd9,  0, 1, 1, 8'd2, 16'd0, "err5");
    applyStimulus(0, 1, 0, 4'd10, 0, 0, 1, 8'd2, 16'd0, "sync5");
    applyStimulus(0, 1, 0, 4'd11, 1, 0, 1, 8'd2, 16'd0, "lock5");
    applyStimulus(0, 1, 0, 4'd0,  0, 1, 1, 8'd3, 16'd0, "err6");
    applyStimulus(0, 1, 0, 4'd1,  0, 0, 1, 8'd3, 16'd0, "sync6");
    applyStimulus(0, 1, 0, 4'd2,  1, 0, 1, 8'd3, 16'd0, "lock6");
    applyStimulus(1, 1, 0, 4'd3,  0, 0, 0, 8'd0, 16'd0, "midReset");
    applyStimulus(0, 1, 0, 4'd7,  0, 0, 0, 8'd0, 16'd0, "idleEntry");
    applyStimulus(0, 1, 0, 4'd8,  0, 0, 0, 8'd0, 16'd0, "sync7");
    applyStimulus(0, 1, 0, 4'd9,  1, 0, 0, 8'd0, 16'd0, "lock7");

    // Wrap-around: 0..15,0..15 from reset. The second 0 is a locked wrap.
    applyStimulus(1, 0, 0, 4'd0, 0, 0, 0, 8'd0, 16'd0, "wrapReset");
    for (int i = 0; i < 32; i++)
      applyStimulus(0, 1, 0, 4'(i), (i >= 2), 0, 0, 8'd0, 16'((i >= 16) ? 1 : 0), "wrap");

    // Error counter saturation at 255: error, then two samples to relock
    expVal = 4'd0;
    for (int k = 1; k <= 257; k++) begin
      applyStimulus(0, 1, 0, expVal + 4'd5, 0, 1, 1, 8'((k > 255) ? 255 : k), 16'd1, "errSat");
      applyStimulus(0, 1, 0, expVal + 4'd6, 0, 0, 1, 8'((k > 255) ? 255 : k), 16'd1, "satSync");
      applyStimulus(0, 1, 0, expVal + 4'd7, 1, 0, 1, 8'((k > 255) ? 255 : k), 16'd1, "satLock");
      expVal = expVal + 4'd8;
    end

    // Clear without a sample, which leaves wrap_cnt alone. Then reset clears it.
    applyStimulus(0, 0, 1, 4'd0, 1, 0, 0, 8'd0, 16'd1, "clrNoEn");
    applyStimulus(1, 1, 1, 4'd3, 0, 0, 0, 8'd0, 16'd0, "finalReset");

    // Let the monitor drain, with a bound
    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d entries left, want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/syscnt_checker.md
SYSCNT_CHECKER -- requirements
Module: syscnt_checker

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, giving the width of the monitored counter value.
REQ-002 The block SHALL have parameter SYNC_LEN, default 2, giving the number of consecutive correct increments required to lock (range 1..15).
REQ-003 The block SHALL have parameter ERR_W, default 8, giving the width of the error counter.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all logic samples on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: sample-valid qualifier for syscnt.
REQ-007 The block SHALL have port syscnt, input, CNT_W bits: counter value produced by the upstream counter block.
REQ-008 The block SHALL have port clr_err, input, 1 bit: synchronous clear of the error status.
REQ-009 The block SHALL have port locked, output, 1 bit: high while the checker is tracking a valid increment sequence.
REQ-010 The block SHALL have port err_pulse, output, 1 bit: one-cycle strobe on each sequence error.
REQ-011 The block SHALL have port err_sticky, output, 1 bit: latched error flag.
REQ-012 The block SHALL have port err_cnt, output, ERR_W bits: saturating count of sequence errors.
REQ-013 The block SHALL have port wrap_cnt, output, 16 bits: saturating count of wrap-arounds seen while locked (present only with the macro, see REQ-030).

Function
REQ-014 A sample SHALL be accepted on a rising clk edge with en=1; with en=0, state, expected value and all outputs SHALL hold, err_pulse excepted, which SHALL be 0; there is no timeout.
REQ-015 The FSM SHALL have states IDLE, SYNC and LOCK, plus an internal expected value exp (CNT_W bits) and a run counter good_run (4 bits).
REQ-016 In IDLE, an accepted sample SHALL load exp=syscnt+1 mod 2^CNT_W and good_run=0, and the FSM SHALL go to SYNC.
REQ-017 In SYNC, a matching sample (syscnt==exp) SHALL increment good_run and set exp=syscnt+1; when good_run reaches SYNC_LEN the FSM SHALL go to LOCK.
REQ-018 In SYNC, a mismatching sample SHALL reload exp=syscnt+1 and clear good_run, SHALL keep the FSM in SYNC, and SHALL NOT count as an error.
REQ-019 In LOCK, a matching sample SHALL set exp=syscnt+1; comparison SHALL wrap modulo 2^CNT_W, so that 15 followed by 0 is correct for CNT_W=4.
REQ-020 In LOCK, a mismatching sample SHALL assert err_pulse, set err_sticky and increment err_cnt (saturating at 2^ERR_W-1), and SHALL load exp=syscnt+1, clear good_run and return the FSM to SYNC.
REQ-021 locked SHALL equal (state==LOCK); all outputs SHALL be registered, with one cycle of latency from the accepting edge.
REQ-022 clr_err=1 SHALL clear err_sticky and err_cnt on the next edge.
REQ-023 If clr_err coincides with a new error, the error SHALL win: err_sticky=1, err_cnt=1 and err_pulse=1.
REQ-024 clr_err SHALL NOT affect the FSM state, exp, locked or wrap_cnt.

Reset
REQ-025 When rst=1 at a rising clk edge, the FSM SHALL enter IDLE and exp, good_run, locked, err_pulse, err_sticky, err_cnt and wrap_cnt SHALL all be 0.
REQ-026 Reset SHALL have priority over en, clr_err and any in-progress match/mismatch, including reset asserted mid-LOCK.
REQ-027 The first accepted sample after reset release SHALL be handled as in IDLE.

Configuration
REQ-028 The macro SYSCNT_CHK_WRAP_CNT_EN SHALL control the wrap counter.
REQ-029 With SYSCNT_CHK_WRAP_CNT_EN defined, wrap_cnt SHALL increment (saturating at 16'hFFFF) on each matching LOCK sample with syscnt==0, and is cleared only by rst.
REQ-030 Without SYSCNT_CHK_WRAP_CNT_EN, the wrap_cnt port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-031 A bench SHALL cover continuous start-up: reset, then en=1 with syscnt 0,1,2,... -> locked=1 the cycle after sample 2 (SYNC_LEN=2), and err_pulse never set.
REQ-032 A bench SHALL cover an injected error: while locked, supply 5 where 4 is expected -> err_pulse high exactly 1 cycle, err_sticky=1, err_cnt=1, locked=0; then supply 6,7 -> locked=1 the cycle after sample 7.
REQ-033 A bench SHALL cover wrap-around: 32 consecutive samples 0..15,0..15 from reset with the macro defined -> wrap_cnt=1, err_cnt=0.
REQ-034 A bench SHALL cover en gaps: while locked, en=0 for 10 cycles with syscnt set to 9, then en=1 with the correct next value -> locked stays 1 and no error.
REQ-035 A bench SHALL cover clear collision: err_cnt=3 and clr_err=1 on the same edge as a new LOCK mismatch -> err_cnt=1, err_sticky=1, err_pulse=1.
REQ-036 A bench SHALL cover reset mid-operation: locked=1 and err_cnt=3, assert rst for 1 cycle -> all outputs 0 next cycle; the next accepted sample behaves as the IDLE entry sample.
